// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU/mux selects, states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SUBI  = 6'b001010;
    localparam logic [5:0] OP_SUBIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_IMM   = 3'b011;
    localparam logic [2:0] ALUOP_BGTZ  = 3'b100;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WR, ST_WB_MEM, ST_EXEC_R,
        ST_EXEC_I, ST_WB_ALU, ST_BRANCH, ST_JUMP, ST_JR, ST_HALT, ST_ERROR
    } state_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles spent waiting on memory; flags expiry on the last allowed wait cycle.
// Latency: expired is combinational from the count and busy.
// Backpressure: none; TIMEOUT=0 disables expiry entirely.
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic busy,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (busy) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // A completing transfer on the final count is not an error: busy already excludes mem_ready.
            assign expired = busy && (cnt == CW'(TIMEOUT - 1));
        end else begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clr, busy};
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mc_control.sv
// Moore controller sequencing MIPS instructions through a shared-memory multi-cycle datapath.
// Latency: 2-5 cycles per instruction with immediate mem_ready; memory states stall on mem_ready.
// Backpressure: waits on mem_ready in FETCH/MEM_RD/MEM_WR, bounded by the timer; ERROR is terminal.
module mc_control
    import mc_pkg::*;
#(
    parameter int ALUOP_W         = 3,
    parameter int TIMEOUT         = 16,
    parameter int HALT_ON_SYSCALL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    input  logic               resume,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               halted,
    output logic               bus_error
);

    state_t     state, state_nxt;
    logic       is_lw, is_rtype, is_bne;
    logic       expired, timer_busy, timer_clr;
    logic [2:0] alu_op;

    assign timer_busy = (state == ST_FETCH || state == ST_MEM_RD || state == ST_MEM_WR) && !mem_ready;
    assign timer_clr  = (state_nxt != state);

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .busy    (timer_busy),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:    if (mem_ready) state_nxt = ST_DECODE;
                         else if (expired) state_nxt = ST_ERROR;
            ST_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:   state_nxt = ST_MEM_ADDR;
                    OP_RTYPE: begin
                        if (Funct == FN_JR)           state_nxt = ST_JR;
                        else if (Funct == FN_SYSCALL) state_nxt = (HALT_ON_SYSCALL != 0) ? ST_HALT : ST_FETCH;
                        else                          state_nxt = ST_EXEC_R;
                    end
                    OP_BNE, OP_BGTZ: state_nxt = ST_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_SUBI, OP_SUBIU,
                    OP_ANDI, OP_ORI, OP_XORI: state_nxt = ST_EXEC_I;
                    OP_J:            state_nxt = ST_JUMP;
                    default:         state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: state_nxt = is_lw ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) state_nxt = ST_WB_MEM;
                         else if (expired) state_nxt = ST_ERROR;
            ST_MEM_WR:   if (mem_ready) state_nxt = ST_FETCH;
                         else if (expired) state_nxt = ST_ERROR;
            ST_EXEC_R, ST_EXEC_I: state_nxt = ST_WB_ALU;
            ST_WB_MEM, ST_WB_ALU, ST_BRANCH, ST_JUMP, ST_JR: state_nxt = ST_FETCH;
            ST_HALT:     if (resume) state_nxt = ST_FETCH;
            ST_ERROR:    state_nxt = ST_ERROR;
            default:     state_nxt = ST_FETCH;
        endcase
    end

    // Instruction class is captured once in DECODE so later states are immune to IR changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            is_lw     <= 1'b0;
            is_rtype  <= 1'b0;
            is_bne    <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                is_lw    <= (Opcode == OP_LW);
                is_rtype <= (Opcode == OP_RTYPE);
                is_bne   <= (Opcode == OP_BNE);
            end
            if (state_nxt == ST_ERROR) bus_error <= 1'b1;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        alu_op      = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        case (state)
            ST_FETCH: begin
                // IR and PC+4 load only on the cycle the fetch actually completes.
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            ST_DECODE:   ALUSrcB = SRCB_BOFS;
            ST_MEM_ADDR: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
            ST_MEM_RD:   begin MemRead = 1'b1; IorD = 1'b1; end
            ST_MEM_WR:   begin MemWrite = 1'b1; IorD = 1'b1; end
            ST_WB_MEM:   begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            ST_EXEC_R:   begin ALUSrcA = 1'b1; alu_op = ALUOP_FUNCT; end
            ST_EXEC_I:   begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; alu_op = ALUOP_IMM; end
            ST_WB_ALU:   begin RegWrite = 1'b1; RegDst = is_rtype; end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                alu_op      = is_bne ? ALUOP_SUB : ALUOP_BGTZ;
            end
            ST_JUMP:     begin PCWrite = 1'b1; PCSource = PCSRC_JUMP; end
            ST_JR:       begin PCWrite = 1'b1; PCSource = PCSRC_REG; end
            default: ;
        endcase
    end

    assign ALUOp  = ALUOP_W'(alu_op);
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_mc_control.sv
// Randomized scoreboard bench: per-instruction step scripts predict every cycle's control word.
module tb_mc_control;

    localparam int TO = 4;

    localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MW = 4, S_WBM = 5, S_EXR = 6,
                   S_EXI = 7, S_WBA = 8, S_BR = 9, S_J = 10, S_JR = 11, S_H = 12, S_E = 13;
    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BNE = 4, C_BGTZ = 5,
                   C_J = 6, C_JR = 7, C_SYS = 8, C_NOP = 9;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       halted, bus_error;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Opcode = '0, Funct = '0;
    logic       mem_ready = 1'b0, resume = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
    logic       RegWrite, ALUSrcA, halted, bus_error;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;

    always #5 clk = ~clk;

    mc_control #(.ALUOP_W(3), .TIMEOUT(TO), .HALT_ON_SYSCALL(1)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
        .resume(resume), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .halted(halted), .bus_error(bus_error)
    );

    ctl_t q[$];
    int   sq[$];
    int   checks = 0, errors = 0;

    // Control word each step must present, straight from the per-state output table.
    function automatic ctl_t exp_ctl(input int step, input bit mr, input bit rt, input bit bne);
        ctl_t c;
        c = '0;
        case (step)
            S_F:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            S_D:   c.alu_src_b = 2'b11;
            S_MA:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MR:  begin c.mem_read = 1; c.iord = 1; end
            S_MW:  begin c.mem_write = 1; c.iord = 1; end
            S_WBM: begin c.reg_write = 1; c.mem_to_reg = 1; end
            S_EXR: begin c.alu_src_a = 1; c.alu_op = 3'b010; end
            S_EXI: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b011; end
            S_WBA: begin c.reg_write = 1; c.reg_dst = rt; end
            S_BR:  begin
                c.alu_src_a = 1; c.pc_write_cond = 1; c.pc_source = 2'b01;
                c.alu_op = bne ? 3'b001 : 3'b100;
            end
            S_J:   begin c.pc_write = 1; c.pc_source = 2'b10; end
            S_JR:  begin c.pc_write = 1; c.pc_source = 2'b11; end
            S_H:   c.halted = 1;
            S_E:   c.bus_error = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic bit rb();
        return ($urandom_range(0, 1) != 0);
    endfunction

    // Monitor: compares the DUT against the oldest prediction on every falling edge.
    ctl_t act, e;
    int   s;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            s = sq.pop_front();
            act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, bus_error};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctl step=%0d t=%0t: got %h expected %h", s, $time, act, e);
            end
        end
    end

    // One clock of stimulus; IR fields are only meaningful in DECODE, so they are scrambled elsewhere.
    task automatic cyc(input int step, input bit mr, input bit rs, input bit rt, input bit bne,
                       input logic [5:0] op, input logic [5:0] fn);
        mem_ready = mr;
        resume    = rs;
        Opcode    = (step == S_D) ? op : 6'($urandom);
        Funct     = (step == S_D) ? fn : 6'($urandom);
        q.push_back(exp_ctl(step, mr, rt, bne));
        sq.push_back(step);
        @(posedge clk);
        #1;
    endtask

    task automatic do_error_reset();
        repeat (3) cyc(S_E, rb(), rb(), 0, 0, 6'd0, 6'd0);
        rst_n = 1'b0;
        cyc(S_F, 1'b0, rb(), 0, 0, 6'd0, 6'd0);
        rst_n = 1'b1;
    endtask

    // A memory wait: completes on mem_ready, or errors after TO consecutive idle cycles.
    task automatic wait_step(input int step, input bit rnd, input int delay, output bit err);
        err = 0;
        for (int k = 0; k < 1000; k++) begin
            bit mr;
            mr = rnd ? ($urandom_range(0, 3) != 0) : (k >= delay);
            cyc(step, mr, rb(), 0, 0, 6'd0, 6'd0);
            if (mr) return;
            if (k == TO - 1) begin
                err = 1;
                return;
            end
        end
    endtask

    task automatic run_instr(input int cls, input bit rnd, input int delay, input int resume_at);
        logic [5:0] op, fn;
        logic [5:0] nops[6];
        bit         rt, bne, err, rs;
        nops = '{6'b000001, 6'b000100, 6'b000110, 6'b001111, 6'b100000, 6'b111111};
        rt = 0; bne = 0; op = 6'd0; fn = 6'($urandom);
        case (cls)
            C_R: begin
                rt = 1;
                while (fn == 6'b001000 || fn == 6'b001100) fn = 6'($urandom);
            end
            C_I:    op = 6'($urandom_range(8, 14));
            C_LW:   op = 6'b100011;
            C_SW:   op = 6'b101011;
            C_BNE:  begin op = 6'b000101; bne = 1; end
            C_BGTZ: op = 6'b000111;
            C_J:    op = 6'b000010;
            C_JR:   fn = 6'b001000;
            C_SYS:  fn = 6'b001100;
            default: op = nops[$urandom_range(0, 5)];
        endcase

        wait_step(S_F, rnd, 0, err);
        if (err) begin do_error_reset(); return; end
        cyc(S_D, rb(), rb(), rt, bne, op, fn);

        case (cls)
            C_R:  begin cyc(S_EXR, rb(), rb(), rt, bne, op, fn); cyc(S_WBA, rb(), rb(), rt, bne, op, fn); end
            C_I:  begin cyc(S_EXI, rb(), rb(), rt, bne, op, fn); cyc(S_WBA, rb(), rb(), rt, bne, op, fn); end
            C_LW: begin
                cyc(S_MA, rb(), rb(), rt, bne, op, fn);
                wait_step(S_MR, rnd, delay, err);
                if (err) begin do_error_reset(); return; end
                cyc(S_WBM, rb(), rb(), rt, bne, op, fn);
            end
            C_SW: begin
                cyc(S_MA, rb(), rb(), rt, bne, op, fn);
                wait_step(S_MW, rnd, delay, err);
                if (err) begin do_error_reset(); return; end
            end
            C_BNE, C_BGTZ: cyc(S_BR, rb(), rb(), rt, bne, op, fn);
            C_J:  cyc(S_J, rb(), rb(), rt, bne, op, fn);
            C_JR: cyc(S_JR, rb(), rb(), rt, bne, op, fn);
            C_SYS: begin
                for (int h = 0; h < 40; h++) begin
                    rs = (resume_at >= 0) ? (h == resume_at) : ($urandom_range(0, 3) == 0);
                    if (h == 39) rs = 1;
                    cyc(S_H, rb(), rs, rt, bne, op, fn);
                    if (rs) break;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(S_F, 1'b0, 1'b0, 0, 0, 6'd0, 6'd0);
        rst_n = 1'b1;

        run_instr(C_R,    0, 0, -1);
        run_instr(C_LW,   0, 3, -1);
        run_instr(C_BGTZ, 0, 0, -1);
        run_instr(C_BNE,  0, 0, -1);
        run_instr(C_JR,   0, 0, -1);
        run_instr(C_J,    0, 0, -1);
        run_instr(C_SYS,  0, 0, 9);
        run_instr(C_SW,   0, 1000, -1);
        run_instr(C_I,    0, 0, -1);

        for (int n = 0; n < 400; n++) begin
            run_instr($urandom_range(0, 9), 1, 0, -1);
        end

        for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
